mbledhesi_serik: RTL and testbench

MBLEDHESI_SERIK -- requirements
Module: mbledhesi_serik

---
 rtl/mbledhesi_serik_pkg.sv | 14 +
 rtl/mbledhesi_digit.sv | 31 +++
 rtl/mbledhesi_serik.sv | 143 ++++++++++++++
 tb/tb_mbledhesi_serik.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mbledhesi_serik_pkg.sv
// Shared definitions for the digit-serial adder/subtractor: controller states
// and the operation-mode encoding of the SUB input.
package mbledhesi_serik_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/mbledhesi_digit.sv
// Combinational DIGIT-bit ripple-carry slice; also exposes the carry into its
// top bit so the caller can form two's-complement overflow on the last digit.
module mbledhesi_digit
  import mbledhesi_serik_pkg::*;
#(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [DIGIT:0] carry;

  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int i = 0; i < DIGIT; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i+1]   = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

  assign cout  = carry[DIGIT];
  assign c_msb = carry[DIGIT-1];

endmodule

// File: rtl/mbledhesi_serik.sv
// Digit-serial adder/subtractor: operands are consumed DIGIT bits per cycle,
// LSB first, and the result is assembled by shifting digits in from the MSB side.
module mbledhesi_serik
  import mbledhesi_serik_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  input  logic             SUB,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT,
  output logic             OVF,
  output logic             ZERO
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  generate
    if (WIDTH % DIGIT != 0) begin : g_bad_digit
      $error("mbledhesi_serik: WIDTH must be a multiple of DIGIT");
    end
  endgenerate

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               zero_q, zero_d;

  logic [DIGIT-1:0]       dig_sum;
  logic                   dig_cout;
  logic                   dig_cmsb;
  logic [WIDTH+DIGIT-1:0] sum_cat;
  logic [WIDTH-1:0]       sum_shift;
  logic                   last_step;

  mbledhesi_digit #(
    .DIGIT(DIGIT)
  ) u_digit (
    .a     (a_q[DIGIT-1:0]),
    .b     (b_q[DIGIT-1:0]),
    .cin   (carry_q),
    .sum   (dig_sum),
    .cout  (dig_cout),
    .c_msb (dig_cmsb)
  );

  // New digit enters at the top; after STEPS shifts the first digit sits at bit 0.
  assign sum_cat   = {dig_sum, sum_q};
  assign sum_shift = sum_cat[WIDTH+DIGIT-1:DIGIT];
  assign last_step = (cnt_q == CNT_W'(STEPS - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;

    case (state_q)
      ST_IDLE: begin
        if (IN_VALID) begin
          a_d     = A;
          b_d     = (SUB == MODE_SUB) ? ~B : B;
          carry_d = (SUB == MODE_SUB) ? 1'b1 : CIN;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        sum_d   = sum_shift;
        carry_d = dig_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_step) begin
          // Flags are taken from the slice that produced the result MSB.
          cout_d  = dig_cout;
          ovf_d   = dig_cout ^ dig_cmsb;
          zero_d  = (sum_shift == '0);
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (OUT_READY) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign IN_READY  = (state_q == ST_IDLE);
  assign OUT_VALID = (state_q == ST_DONE);
  assign SUM       = sum_q;
  assign COUT      = cout_q;
  assign OVF       = ovf_q;
  assign ZERO      = zero_q;

endmodule

// File: tb/tb_mbledhesi_serik.sv
// Bench for mbledhesi_serik: three instances (DIGIT 4, 1, 16) share one
// stimulus stream and are checked against hand-computed vectors and a model.
module tb_mbledhesi_serik;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_ovf;
    logic         exp_zero;
  } vec_t;

  logic              CLK = 1'b0;
  logic              RESET_N;
  logic              in_valid;
  logic [W-1:0]      a_in;
  logic [W-1:0]      b_in;
  logic              cin_in;
  logic              sub_in;
  logic              out_ready;
  logic [2:0]        in_ready_v;
  logic [2:0]        out_valid_v;
  logic [2:0][W-1:0] sum_v;
  logic [2:0]        cout_v;
  logic [2:0]        ovf_v;
  logic [2:0]        zero_v;

  int pass_count  = 0;
  int check_count = 0;
  int steps_v[3]  = '{4, 16, 1};

  always #5 CLK = ~CLK;

  mbledhesi_serik #(.WIDTH(W), .DIGIT(4)) dut_d4 (
    .CLK(CLK), .RESET_N(RESET_N), .IN_VALID(in_valid), .IN_READY(in_ready_v[0]),
    .A(a_in), .B(b_in), .CIN(cin_in), .SUB(sub_in),
    .OUT_VALID(out_valid_v[0]), .OUT_READY(out_ready),
    .SUM(sum_v[0]), .COUT(cout_v[0]), .OVF(ovf_v[0]), .ZERO(zero_v[0])
  );

  mbledhesi_serik #(.WIDTH(W), .DIGIT(1)) dut_d1 (
    .CLK(CLK), .RESET_N(RESET_N), .IN_VALID(in_valid), .IN_READY(in_ready_v[1]),
    .A(a_in), .B(b_in), .CIN(cin_in), .SUB(sub_in),
    .OUT_VALID(out_valid_v[1]), .OUT_READY(out_ready),
    .SUM(sum_v[1]), .COUT(cout_v[1]), .OVF(ovf_v[1]), .ZERO(zero_v[1])
  );

  mbledhesi_serik #(.WIDTH(W), .DIGIT(16)) dut_d16 (
    .CLK(CLK), .RESET_N(RESET_N), .IN_VALID(in_valid), .IN_READY(in_ready_v[2]),
    .A(a_in), .B(b_in), .CIN(cin_in), .SUB(sub_in),
    .OUT_VALID(out_valid_v[2]), .OUT_READY(out_ready),
    .SUM(sum_v[2]), .COUT(cout_v[2]), .OVF(ovf_v[2]), .ZERO(zero_v[2])
  );

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_count++;
    if (act === exp) pass_count++;
    else $display("[TB] FAIL %s: got %0h, wanted %0h", name, act, exp);
  endtask

  // Drives operands and holds IN_VALID across exactly one rising edge.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic cin, input logic sub);
    a_in     = a;
    b_in     = b;
    cin_in   = cin;
    sub_in   = sub;
    in_valid = 1'b1;
    @(negedge CLK);
    in_valid = 1'b0;
  endtask

  // Waits (bounded) for each instance's OUT_VALID, then checks latency and result.
  task automatic checkOutput(input string tag, input logic [W-1:0] e_sum,
                             input logic e_cout, input logic e_ovf, input logic e_zero);
    int           lat[3];
    logic [W-1:0] s[3];
    logic         c[3];
    logic         o[3];
    logic         z[3];
    for (int d = 0; d < 3; d++) begin
      lat[d] = -1; s[d] = '0; c[d] = 1'b0; o[d] = 1'b0; z[d] = 1'b0;
    end
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge CLK);
      for (int d = 0; d < 3; d++) begin
        if (lat[d] < 0 && out_valid_v[d]) begin
          lat[d] = cyc; s[d] = sum_v[d]; c[d] = cout_v[d]; o[d] = ovf_v[d]; z[d] = zero_v[d];
        end
      end
      if (lat[0] >= 0 && lat[1] >= 0 && lat[2] >= 0) break;
    end
    for (int d = 0; d < 3; d++) begin
      compare($sformatf("%s d%0d latency", tag, 16 / steps_v[d]), lat[d], steps_v[d]);
      compare($sformatf("%s d%0d sum", tag, 16 / steps_v[d]), {16'h0, s[d]}, {16'h0, e_sum});
      compare($sformatf("%s d%0d cout", tag, 16 / steps_v[d]), {31'h0, c[d]}, {31'h0, e_cout});
      compare($sformatf("%s d%0d ovf", tag, 16 / steps_v[d]), {31'h0, o[d]}, {31'h0, e_ovf});
      compare($sformatf("%s d%0d zero", tag, 16 / steps_v[d]), {31'h0, z[d]}, {31'h0, e_zero});
    end
  endtask

  function automatic vec_t ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic cin, input logic sub);
    vec_t         v;
    logic [W-1:0] bb;
    logic [W:0]   r;
    bb         = sub ? ~b : b;
    r          = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
    v.a        = a;
    v.b        = b;
    v.cin      = cin;
    v.sub      = sub;
    v.exp_sum  = r[W-1:0];
    v.exp_cout = r[W];
    v.exp_ovf  = (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]);
    v.exp_zero = (r[W-1:0] == '0);
    return v;
  endfunction

  vec_t vecs[10];

  initial begin
    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
    vecs[8] = '{16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000F, 1'b1, 1'b0, 1'b0};
    vecs[9] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};

    RESET_N   = 1'b0;
    in_valid  = 1'b0;
    a_in      = '0;
    b_in      = '0;
    cin_in    = 1'b0;
    sub_in    = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge CLK);
    for (int d = 0; d < 3; d++)
      compare($sformatf("reset state d%0d", d),
              {12'h0, out_valid_v[d], in_ready_v[d], sum_v[d], cout_v[d], ovf_v[d], zero_v[d]},
              {12'h0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0});
    RESET_N = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_sum, vecs[i].exp_cout,
                  vecs[i].exp_ovf, vecs[i].exp_zero);
    end

    for (int i = 0; i < 12; i++) begin
      vec_t r;
      r = ref_model(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      @(negedge CLK);
      applyStimulus(r.a, r.b, r.cin, r.sub);
      checkOutput($sformatf("rand%0d", i), r.exp_sum, r.exp_cout, r.exp_ovf, r.exp_zero);
    end

    // Consumer stalls in DONE while new operands keep arriving.
    @(negedge CLK);
    out_ready = 1'b0;
    applyStimulus(16'h1234, 16'h4321, 1'b0, 1'b0);
    for (int cyc = 0; cyc < 40 && out_valid_v != 3'b111; cyc++) @(negedge CLK);
    compare("stall all done", {29'h0, out_valid_v}, 32'h7);
    for (int cyc = 0; cyc < 10; cyc++) begin
      in_valid = cyc[0];
      a_in     = W'($urandom);
      b_in     = W'($urandom);
      sub_in   = 1'($urandom);
      @(negedge CLK);
      for (int d = 0; d < 3; d++)
        compare($sformatf("stall c%0d d%0d", cyc, d),
                {12'h0, out_valid_v[d], in_ready_v[d], sum_v[d], cout_v[d], ovf_v[d], zero_v[d]},
                {12'h0, 1'b1, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge CLK);
    compare("stall release idle", {26'h0, out_valid_v, in_ready_v}, {26'h0, 3'b000, 3'b111});
    @(negedge CLK);
    compare("stall no second accept", {26'h0, out_valid_v, in_ready_v}, {26'h0, 3'b000, 3'b111});

    // Reset lands in the second RUN cycle.
    applyStimulus(16'h1111, 16'h2222, 1'b0, 1'b0);
    @(negedge CLK);
    compare("pre-reset no valid", {30'h0, out_valid_v[1:0]}, 32'h0);
    RESET_N = 1'b0;
    #1;
    for (int d = 0; d < 3; d++)
      compare($sformatf("mid-run reset d%0d", d),
              {12'h0, out_valid_v[d], in_ready_v[d], sum_v[d], cout_v[d], ovf_v[d], zero_v[d]},
              {12'h0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0});
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge CLK);
      compare($sformatf("reset hold c%0d", cyc), {29'h0, out_valid_v}, 32'h0);
    end
    RESET_N = 1'b1;
    applyStimulus(16'h0F0F, 16'h00F1, 1'b1, 1'b0);
    checkOutput("post-reset", 16'h1001, 1'b0, 1'b0, 1'b0);

    repeat (3) @(negedge CLK);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
